// File: rtl/ctrl_pkg.sv
// Shared control-unit types: state width, next-state and condition encodings.
package ctrl_pkg;

  localparam int unsigned STATE_W = 6;
  localparam int unsigned CNT_W   = 8;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    NS_ENC = 2'b00,
    NS_INC = 2'b01,
    NS_JMP = 2'b10,
    NS_CBR = 2'b11
  } ns_sel_e;

  typedef enum logic [1:0] {
    CS_MOC  = 2'b00,
    CS_COND = 2'b01,
    CS_ONE  = 2'b10,
    CS_ZERO = 2'b11
  } cond_sel_e;

  // Encoder output reserved for opcodes with no microcode
  localparam state_t UNIMPL_STATE = 6'd63;

endpackage

// File: rtl/next_state_mux.sv
// Candidate next-state selection: condition select/invert and source mux.
module next_state_mux
  import ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] enc_state,
  input  logic [1:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic [STATE_W-1:0] target,
  input  logic               moc,
  input  logic               cond_true,
  output logic [STATE_W-1:0] nxt_c
);

  logic   cond_raw;
  logic   cond;
  state_t state_inc;

  // Select the branch condition and apply optional inversion
  always_comb begin
    cond_raw = 1'b0;
    case (cond_sel_e'(cond_sel))
      CS_MOC:  cond_raw = moc;
      CS_COND: cond_raw = cond_true;
      CS_ONE:  cond_raw = 1'b1;
      CS_ZERO: cond_raw = 1'b0;
      default: cond_raw = 1'b0;
    endcase
    cond = cond_raw ^ inv;
  end

  // Source mux; increment wraps modulo 64
  always_comb begin
    state_inc = state + STATE_W'(1);
    nxt_c     = state_inc;
    case (ns_sel_e'(ns_sel))
      NS_ENC:  nxt_c = enc_state;
      NS_INC:  nxt_c = state_inc;
      NS_JMP:  nxt_c = target;
      NS_CBR:  nxt_c = cond ? target : state_inc;
      default: nxt_c = state_inc;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: control-state register with illegal-opcode and
// memory-wait timeout traps into a common fault state.
module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned FAULT_STATE = 62,
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] enc_state,
  input  logic [1:0]         ns_sel,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic [STATE_W-1:0] target,
  input  logic               moc,
  input  logic               cond_true,
  input  logic               hold,
  output logic [STATE_W-1:0] state,
  output logic               illegal,
  output logic               bus_fault
);

  localparam state_t           RST_S = STATE_W'(RESET_STATE);
  localparam state_t           FLT_S = STATE_W'(FAULT_STATE);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(MOC_TIMEOUT);

  state_t           nxt_c;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             illegal_d;
  logic             bus_fault_d;

  next_state_mux u_mux (
    .state     (state),
    .enc_state (enc_state),
    .ns_sel    (ns_sel),
    .cond_sel  (cond_sel),
    .inv       (inv),
    .target    (target),
    .moc       (moc),
    .cond_true (cond_true),
    .nxt_c     (nxt_c)
  );

  // Trap priority and self-loop counting; hold freezes everything
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    illegal_d   = 1'b0;
    bus_fault_d = 1'b0;
    if (!hold) begin
      if ((ns_sel == NS_ENC) && (enc_state == UNIMPL_STATE)) begin
        state_d   = FLT_S;
        cnt_d     = '0;
        illegal_d = 1'b1;
      end else if (nxt_c == state) begin
        if (cnt == TO_C) begin
          state_d     = FLT_S;
          cnt_d       = '0;
          bus_fault_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end else begin
        state_d = nxt_c;
        cnt_d   = '0;
      end
    end
  end

  // State, loop counter and trap pulses, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RST_S;
      cnt       <= '0;
      illegal   <= 1'b0;
      bus_fault <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      illegal   <= illegal_d;
      bus_fault <= bus_fault_d;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: driver queues expected outputs,
// monitor pops and compares after each rising edge.
module tb_micro_sequencer;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] enc_state;
  logic [1:0] ns_sel;
  logic [1:0] cond_sel;
  logic       inv;
  logic [5:0] target;
  logic       moc;
  logic       cond_true;
  logic       hold;
  logic [5:0] state;
  logic       illegal;
  logic       bus_fault;

  typedef struct {
    logic [5:0] s;
    logic       i;
    logic       b;
    int         n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  bit   drv_done = 1'b0;

  micro_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .enc_state (enc_state),
    .ns_sel    (ns_sel),
    .cond_sel  (cond_sel),
    .inv       (inv),
    .target    (target),
    .moc       (moc),
    .cond_true (cond_true),
    .hold      (hold),
    .state     (state),
    .illegal   (illegal),
    .bus_fault (bus_fault)
  );

  always #5 clk = ~clk;

  // Queue the expected post-edge outputs for the current inputs, then clock
  task automatic cyc(input logic [5:0] es, input logic ei, input logic eb);
    exp_t e;
    e.s = es; e.i = ei; e.b = eb; e.n = step_no;
    exp_q.push_back(e);
    step_no++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_jmp(input logic [5:0] t);
    ns_sel = NS_JMP; target = t; inv = 1'b0; cond_sel = CS_ZERO;
  endtask

  task automatic set_wait(input logic [5:0] t);
    ns_sel = NS_CBR; cond_sel = CS_MOC; inv = 1'b1; target = t; moc = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (state !== e.s || illegal !== e.i || bus_fault !== e.b) begin
          failures++;
          $display("FAIL step%0d: state=%0d illegal=%b bus_fault=%b expected state=%0d illegal=%b bus_fault=%b",
                   e.n, state, illegal, bus_fault, e.s, e.i, e.b);
        end
      end
    end
  end

  // Driver: directed vectors
  initial begin
    reset = 1'b0; enc_state = '0; ns_sel = NS_INC; cond_sel = CS_ZERO;
    inv = 1'b0; target = '0; moc = 1'b0; cond_true = 1'b0; hold = 1'b0;
    @(negedge clk);

    // Reset from unknown, then from state 17
    cyc(6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    set_jmp(6'd17);
    cyc(6'd17, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(6'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // Encoder dispatch and increments
    ns_sel = NS_ENC; enc_state = 6'd5;
    cyc(6'd5, 1'b0, 1'b0);
    ns_sel = NS_INC;
    cyc(6'd6, 1'b0, 1'b0);
    cyc(6'd7, 1'b0, 1'b0);

    // Wrap and conditional branch with constant condition
    set_jmp(6'd63);
    cyc(6'd63, 1'b0, 1'b0);
    ns_sel = NS_INC;
    cyc(6'd0, 1'b0, 1'b0);
    ns_sel = NS_CBR; cond_sel = CS_ONE; inv = 1'b0; target = 6'd40;
    cyc(6'd40, 1'b0, 1'b0);
    inv = 1'b1;
    cyc(6'd41, 1'b0, 1'b0);
    // cond_true path: true jumps, false increments
    cond_sel = CS_COND; inv = 1'b0; cond_true = 1'b1; target = 6'd10;
    cyc(6'd10, 1'b0, 1'b0);
    cond_true = 1'b0;
    cyc(6'd11, 1'b0, 1'b0);

    // Illegal opcode trap, single pulse
    ns_sel = NS_ENC; enc_state = 6'd63;
    cyc(6'd62, 1'b1, 1'b0);
    set_jmp(6'd3);
    cyc(6'd3, 1'b0, 1'b0);
    // Hold suppresses the trap
    ns_sel = NS_ENC; enc_state = 6'd63; hold = 1'b1;
    cyc(6'd3, 1'b0, 1'b0);
    hold = 1'b0;
    set_jmp(6'd0);
    cyc(6'd0, 1'b0, 1'b0);

    // MOC wait timeout: 15 counted loops, fault on the next edge
    set_jmp(6'd20);
    cyc(6'd20, 1'b0, 1'b0);
    set_wait(6'd20);
    for (int i = 0; i < 15; i++) cyc(6'd20, 1'b0, 1'b0);
    cyc(6'd62, 1'b0, 1'b1);
    set_jmp(6'd0);
    cyc(6'd0, 1'b0, 1'b0);

    // MOC arrives when the count hits the timeout: exits, no fault
    set_jmp(6'd20);
    cyc(6'd20, 1'b0, 1'b0);
    set_wait(6'd20);
    for (int i = 0; i < 15; i++) cyc(6'd20, 1'b0, 1'b0);
    moc = 1'b1;
    cyc(6'd21, 1'b0, 1'b0);
    // Count restarted: a fresh full wait is needed before faulting
    set_wait(6'd21);
    for (int i = 0; i < 15; i++) cyc(6'd21, 1'b0, 1'b0);
    cyc(6'd62, 1'b0, 1'b1);

    // Hold mid-wait freezes the count
    set_jmp(6'd20);
    cyc(6'd20, 1'b0, 1'b0);
    set_wait(6'd20);
    for (int i = 0; i < 5; i++) cyc(6'd20, 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) cyc(6'd20, 1'b0, 1'b0);
    hold = 1'b0;
    for (int i = 0; i < 10; i++) cyc(6'd20, 1'b0, 1'b0);
    cyc(6'd62, 1'b0, 1'b1);

    // Reset at loop count 12 discards the count
    set_jmp(6'd20);
    cyc(6'd20, 1'b0, 1'b0);
    set_wait(6'd20);
    for (int i = 0; i < 12; i++) cyc(6'd20, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(6'd0, 1'b0, 1'b0);
    reset = 1'b1;
    set_jmp(6'd20);
    cyc(6'd20, 1'b0, 1'b0);
    set_wait(6'd20);
    for (int i = 0; i < 15; i++) cyc(6'd20, 1'b0, 1'b0);
    cyc(6'd62, 1'b0, 1'b1);
    set_jmp(6'd0);
    cyc(6'd0, 1'b0, 1'b0);

    drv_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then summarise
  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (!drv_done || exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: driver_done=%0d pending=%0d expected driver_done=1 pending=0",
               drv_done, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the control unit. Holds the current control-state register that addresses the microstore, and each cycle selects the next state from one of four sources: the instruction encoder's 6-bit start state, an increment, an unconditional target, or a conditional target. Sits between the instruction encoder (input) and the microstore (output address). Also detects unimplemented opcodes and hung memory waits, and diverts both to a fault state.

## Interface
- `RESET_STATE`, default 0: state loaded on reset (fetch entry).
- `FAULT_STATE`, default 62: state forced on illegal opcode or memory timeout.
- `MOC_TIMEOUT`, default 15: consecutive self-loop cycles tolerated before fault; legal range 1–255.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enc_state`  in  6  start state from the instruction encoder; 63 means unimplemented.
- `ns_sel`  in  2  next-state source from the current microinstruction: 00 encoder, 01 increment, 10 jump, 11 conditional.
- `cond_sel`  in  2  condition source: 00 `moc`, 01 `cond_true`, 10 constant 1, 11 constant 0.
- `inv`  in  1  invert the selected condition.
- `target`  in  6  jump/branch target from the microinstruction.
- `moc`  in  1  memory operation complete.
- `cond_true`  in  1  result of the instruction condition tester.
- `hold`  in  1  debug stall; freezes all registers.
- `state`  out  6  current control state (microstore address).
- `illegal`  out  1  registered one-cycle pulse: unimplemented opcode trapped.
- `bus_fault`  out  1  registered one-cycle pulse: MOC timeout trapped.

## Operation
- The condition is the `cond_sel`-selected signal XOR `inv`.
- Candidate next state (`nxt`):
  - `ns_sel`=00: `enc_state`.
  - 01: `state+1`, 6-bit modulo, so 63 wraps to 0.
  - 10: `target`.
  - 11: `target` if the condition is 1, else `state+1` (wrapping).
- Illegal trap: if `ns_sel`=00 and `enc_state`=63, next state is `FAULT_STATE` and `illegal` pulses.
- Loop counter (8 bits):
  - Increments when `nxt == state` and no trap applies.
  - Otherwise clears to 0.
- Timeout: when the counter equals `MOC_TIMEOUT` and `nxt == state` again, the next state is `FAULT_STATE`, `bus_fault` pulses, and the counter clears.
- The normal wait idiom is `ns_sel`=11, `cond_sel`=00, `inv`=1, `target`=`state` (loop until `moc`).
- Priority, highest first: `reset` > `hold` > illegal trap > timeout > normal selection.
- `hold`=1 freezes `state` and the counter, and forces `illegal`/`bus_fault` to 0.
- Illegal trap and timeout cannot coincide: an illegal trap implies `nxt` (63) differs from a counted loop, because the trap takes priority and clears the counter.

## Timing
- Reset values: `state`=`RESET_STATE`, counter=0, `illegal`=0, `bus_fault`=0. Reset mid-wait discards the loop count.
- Microstore read is combinational from `state`. The microinstruction inputs are valid in the same cycle; `nxt` is combinational.
- Latency is one cycle: inputs sampled at edge k determine `state` after edge k.
- `illegal`/`bus_fault` assert in the same cycle that `state` becomes `FAULT_STATE`, for exactly one cycle. No repeat pulses unless the trap condition recurs.
- In a self-loop, `FAULT_STATE` is entered on the edge after `MOC_TIMEOUT` looped cycles.
- `moc` arriving in the same cycle the counter reaches `MOC_TIMEOUT`: the condition is false, so `nxt` = `state+1`. No fault; the counter clears.

## Structure
- Shared package `ctrl_pkg`: `ns_sel` encodings (`NS_ENC`, `NS_INC`, `NS_JMP`, `NS_CBR`), `cond_sel` encodings, `UNIMPL_STATE`=63, the 6-bit state type.
- One combinational sub-module, `next_state_mux`: condition select/invert plus source mux producing `nxt`.
- Trap logic, counter and registers stay in `micro_sequencer`.

## Test plan
- Reset low one edge with `state`=17 → `state`=0, `illegal`=0, `bus_fault`=0.
- `ns_sel`=00, `enc_state`=5 → `state`=5 next cycle. Then `ns_sel`=01 for two cycles → 6, then 7.
- `state`=63, `ns_sel`=01 → 0 (wrap). `ns_sel`=11, `cond_sel`=10, `target`=40 → 40. Same with `inv`=1 → 41.
- `ns_sel`=00, `enc_state`=63 → `state`=62, `illegal` high exactly one cycle.
- MOC wait at state 20 with `moc`=0:
  - Stays at 20 for 15 cycles, then → 62 with `bus_fault` pulse.
  - Repeat with `moc`=1 on the 15th cycle → 21, no fault.
- `hold`=1 for 10 cycles during a MOC wait → `state` and counter frozen, no fault.
- Sync reset asserted mid-wait at loop count 12 → `state`=0, counter 0; a subsequent 15-cycle wait still needs the full count.
